// File: rtl/ni_link_ctrl.sv
// ni_link_ctrl: sequencing controller between the pipeline and the network
// interface. It queues outgoing sends in a first-word-fall-through FIFO and
// schedules one held incoming NI word onto the register-file write port,
// which is shared with pipeline writeback.
module ni_link_ctrl #(
    parameter int         DATA_W     = 32,
    parameter int         NODE_W     = 2,
    parameter int         TX_DEPTH   = 4,
    parameter int         STARVE_MAX = 8,
    parameter logic [4:0] RX_REG     = 5'd30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] current_node,
    input  logic              tx_req,
    input  logic [NODE_W-1:0] tx_dest,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_stall,
    output logic              ni_valid,
    output logic [NODE_W-1:0] ni_dest,
    output logic [DATA_W-1:0] ni_data,
    input  logic              ni_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    input  logic              wb_we,
    output logic              wb_hold,
    output logic              rx_we,
    output logic [4:0]        rx_waddr,
    output logic [DATA_W-1:0] rx_wdata,
    output logic [15:0]       tx_sent_cnt
);

    localparam int AW     = $clog2(TX_DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int WCNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FORCE} rx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The node address is carried for debug visibility only.
    logic unused_node;
    assign unused_node = ^current_node;

    // ---------------- TX FIFO ----------------
    logic [NODE_W+DATA_W-1:0] mem_q [TX_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]         occ;
    logic                     full, empty, push, pop;
    logic [15:0]              sent_cnt_q;

    // Occupancy comes from the wrapping pointer difference; full is judged
    // before any pop, so a same-cycle pop never frees room for a push.
    always_comb begin
        occ   = wr_ptr_q - rd_ptr_q;
        full  = (occ == PTR_W'(TX_DEPTH));
        empty = (wr_ptr_q == rd_ptr_q);
        push  = tx_req && !full;
        pop   = !empty && ni_ready;
    end

    assign tx_stall              = tx_req && full;
    assign ni_valid              = !empty;
    assign {ni_dest, ni_data}    = mem_q[rd_ptr_q[AW-1:0]];
    assign tx_sent_cnt           = sent_cnt_q;

    // Pointer and sent-count state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sent_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                sent_cnt_q <= sat_inc16(sent_cnt_q);
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {tx_dest, tx_data};
    end

    // ---------------- RX scheduler ----------------
    rx_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] hold_q;
    logic              capture;

    assign capture  = (state_q == S_IDLE) && rx_valid;
    assign rx_waddr = RX_REG;
    assign rx_wdata = hold_q;

    // State, wait counter and holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (capture) hold_q <= rx_data;
        end
    end

    // Next state: writeback wins the port until the wait budget runs out.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    state_d    = S_HOLD;
                    wait_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (!wb_we) begin
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    if (wait_cnt_d == WCNT_W'(STARVE_MAX)) state_d = S_FORCE;
                end
            end
            S_FORCE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: ready only when idle and out of reset; forced write blocks writeback.
    always_comb begin
        rx_ready = (state_q == S_IDLE) && !rst;
        rx_we    = 1'b0;
        wb_hold  = 1'b0;
        unique case (state_q)
            S_HOLD:  rx_we = !wb_we;
            S_FORCE: begin
                rx_we   = 1'b1;
                wb_hold = wb_we;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ni_link_ctrl.sv
// Self-checking bench for ni_link_ctrl: directed scenarios plus a randomized
// run compared against a queue/counter reference model.
module tb_ni_link_ctrl;

    localparam int DATA_W     = 32;
    localparam int NODE_W     = 2;
    localparam int TX_DEPTH   = 4;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NODE_W-1:0] current_node = 2'd1;
    logic              tx_req = 1'b0;
    logic [NODE_W-1:0] tx_dest = '0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_stall;
    logic              ni_valid;
    logic [NODE_W-1:0] ni_dest;
    logic [DATA_W-1:0] ni_data;
    logic              ni_ready = 1'b0;
    logic              rx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_ready;
    logic              wb_we = 1'b0;
    logic              wb_hold;
    logic              rx_we;
    logic [4:0]        rx_waddr;
    logic [DATA_W-1:0] rx_wdata;
    logic [15:0]       tx_sent_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [NODE_W+DATA_W-1:0] txq[$];
    logic [15:0]              m_cnt = '0;
    bit                       m_held = 0;
    logic [DATA_W-1:0]        m_word = '0;
    int                       m_denied = 0;

    ni_link_ctrl #(
        .DATA_W(DATA_W), .NODE_W(NODE_W), .TX_DEPTH(TX_DEPTH),
        .STARVE_MAX(STARVE_MAX), .RX_REG(5'd30)
    ) dut (
        .clk(clk), .rst(rst), .current_node(current_node),
        .tx_req(tx_req), .tx_dest(tx_dest), .tx_data(tx_data), .tx_stall(tx_stall),
        .ni_valid(ni_valid), .ni_dest(ni_dest), .ni_data(ni_data), .ni_ready(ni_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .wb_we(wb_we), .wb_hold(wb_hold), .rx_we(rx_we), .rx_waddr(rx_waddr),
        .rx_wdata(rx_wdata), .tx_sent_cnt(tx_sent_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit full_m, pop_m, push_m;
        logic [NODE_W+DATA_W-1:0] dummy;
        if (rst) begin
            txq.delete();
            m_cnt = '0; m_held = 0; m_word = '0; m_denied = 0;
            return;
        end
        full_m = (txq.size() == TX_DEPTH);
        pop_m  = (txq.size() != 0) && ni_ready;
        push_m = tx_req && !full_m;
        if (pop_m) begin
            dummy = txq.pop_front();
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        if (push_m) txq.push_back({tx_dest, tx_data});
        if (m_held) begin
            if (!wb_we || m_denied == STARVE_MAX) m_held = 0;
            else m_denied++;
        end else if (rx_valid) begin
            m_held = 1; m_word = rx_data; m_denied = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        tx_req = 0; ni_ready = 0; rx_valid = 0; wb_we = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        tick(); tick();
        #1;
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready_during got=%0b want=0", rx_ready); end
        checks++; if (ni_valid !== 1'b0) begin failures++; $display("FAIL reset_ni_valid got=%0b want=0", ni_valid); end
        checks++; if (rx_we !== 1'b0 || wb_hold !== 1'b0) begin failures++; $display("FAIL reset_rx_we_wb_hold got=%0b%0b want=00", rx_we, wb_hold); end
        checks++; if (rx_wdata !== 32'd0) begin failures++; $display("FAIL reset_rx_wdata got=%h want=0", rx_wdata); end
        checks++; if (tx_sent_cnt !== 16'd0) begin failures++; $display("FAIL reset_sent_cnt got=%h want=0", tx_sent_cnt); end
        rst = 0;
        #1;
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready_after got=%0b want=1", rx_ready); end
        checks++; if (tx_stall !== 1'b0) begin failures++; $display("FAIL reset_tx_stall got=%0b want=0", tx_stall); end
        checks++; if (rx_waddr !== 5'd30) begin failures++; $display("FAIL rx_waddr got=%0d want=30", rx_waddr); end
    endtask

    task automatic test_tx_fill();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tx_req = 1; tx_dest = 2'd2; tx_data = 32'hA1 + i;
            #1;
            checks++; if (tx_stall !== 1'b0) begin failures++; $display("FAIL fill_stall_%0d got=%0b want=0", i, tx_stall); end
            tick();
        end
        tx_data = 32'hA5;
        #1;
        checks++; if (tx_stall !== 1'b1) begin failures++; $display("FAIL fill_fifth_stall got=%0b want=1", tx_stall); end
        checks++; if (ni_valid !== 1'b1 || ni_data !== 32'hA1) begin failures++; $display("FAIL fill_head got=%0b/%h want=1/a1", ni_valid, ni_data); end
        tick();
        tx_req = 0; ni_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ni_valid !== 1'b1 || ni_data !== 32'hA1 + i || ni_dest !== 2'd2) begin
                failures++; $display("FAIL drain_%0d got=%0b/%h/%0d want=1/%h/2", i, ni_valid, ni_data, ni_dest, 32'hA1 + i);
            end
            tick();
        end
        #1;
        checks++; if (ni_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b want=0", ni_valid); end
        checks++; if (tx_sent_cnt !== 16'd4) begin failures++; $display("FAIL drain_sent_cnt got=%0d want=4", tx_sent_cnt); end
        ni_ready = 0;
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] exp_w;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tx_req = 1; tx_dest = 2'd3; tx_data = 32'hB0 + i;
            tick();
        end
        tx_data = 32'hB4; ni_ready = 1;
        #1;
        checks++; if (tx_stall !== 1'b1) begin failures++; $display("FAIL fullpp_stall got=%0b want=1", tx_stall); end
        checks++; if (ni_data !== 32'hB0) begin failures++; $display("FAIL fullpp_head got=%h want=b0", ni_data); end
        tick();
        #1;
        checks++; if (tx_stall !== 1'b0) begin failures++; $display("FAIL fullpp_accept got=%0b want=0", tx_stall); end
        checks++; if (ni_data !== 32'hB1) begin failures++; $display("FAIL fullpp_head2 got=%h want=b1", ni_data); end
        tick();
        tx_req = 0;
        for (int i = 0; i < 3; i++) begin
            exp_w = 32'hB2 + i;
            #1;
            checks++; if (ni_valid !== 1'b1 || ni_data !== exp_w || ni_dest !== 2'd3) begin failures++; $display("FAIL fullpp_drain_%0d got=%0b/%h want=1/%h", i, ni_valid, ni_data, exp_w); end
            tick();
        end
        #1;
        checks++; if (ni_valid !== 1'b0 || tx_sent_cnt !== 16'd9) begin failures++; $display("FAIL fullpp_end got=%0b/%0d want=0/9", ni_valid, tx_sent_cnt); end
        ni_ready = 0;
    endtask

    task automatic test_rx_basic();
        idle_inputs();
        rx_valid = 1; rx_data = 32'h1234;
        #1;
        checks++; if (rx_ready !== 1'b1 || rx_we !== 1'b0) begin failures++; $display("FAIL rx_idle got=%0b/%0b want=1/0", rx_ready, rx_we); end
        tick();
        rx_valid = 0;
        #1;
        checks++;
        if (rx_we !== 1'b1 || rx_waddr !== 5'd30 || rx_wdata !== 32'h1234 || rx_ready !== 1'b0 || wb_hold !== 1'b0) begin
            failures++; $display("FAIL rx_write got=%0b/%0d/%h/%0b want=1/30/1234/0", rx_we, rx_waddr, rx_wdata, rx_ready);
        end
        tick();
        #1;
        checks++; if (rx_ready !== 1'b1 || rx_we !== 1'b0) begin failures++; $display("FAIL rx_back_idle got=%0b/%0b want=1/0", rx_ready, rx_we); end
    endtask

    task automatic test_rx_starve();
        idle_inputs();
        rx_valid = 1; rx_data = 32'hBEEF;
        tick();
        rx_valid = 0; wb_we = 1;
        for (int i = 1; i <= STARVE_MAX; i++) begin
            #1;
            checks++; if (rx_we !== 1'b0 || wb_hold !== 1'b0 || rx_ready !== 1'b0) begin failures++; $display("FAIL starve_wait_%0d got=%0b/%0b/%0b want=0/0/0", i, rx_we, wb_hold, rx_ready); end
            tick();
        end
        #1;
        checks++; if (rx_we !== 1'b1 || wb_hold !== 1'b1 || rx_wdata !== 32'hBEEF) begin failures++; $display("FAIL starve_force got=%0b/%0b/%h want=1/1/beef", rx_we, wb_hold, rx_wdata); end
        tick();
        #1;
        checks++; if (rx_ready !== 1'b1 || rx_we !== 1'b0 || wb_hold !== 1'b0) begin failures++; $display("FAIL starve_idle got=%0b/%0b/%0b want=1/0/0", rx_ready, rx_we, wb_hold); end
        wb_we = 0;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        wb_we = 1;
        tx_req = 1; tx_dest = 2'd1; tx_data = 32'hC1; rx_valid = 1; rx_data = 32'h5A5A;
        tick();
        tx_data = 32'hC2; rx_valid = 0;
        tick();
        tx_req = 0;
        #1;
        checks++; if (ni_valid !== 1'b1 || rx_ready !== 1'b0) begin failures++; $display("FAIL midrst_setup got=%0b/%0b want=1/0", ni_valid, rx_ready); end
        rst = 1;
        tick();
        rst = 0; wb_we = 0;
        #1;
        checks++; if (ni_valid !== 1'b0) begin failures++; $display("FAIL midrst_ni_valid got=%0b want=0", ni_valid); end
        checks++; if (rx_we !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL midrst_rx got=%0b/%0b want=0/1", rx_we, rx_ready); end
        checks++; if (tx_sent_cnt !== 16'd0 || rx_wdata !== 32'd0) begin failures++; $display("FAIL midrst_regs got=%0d/%h want=0/0", tx_sent_cnt, rx_wdata); end
    endtask

    task automatic test_random();
        bit prev_stall = 0;
        bit e_valid, e_stall, e_we, e_hold;
        logic [NODE_W+DATA_W-1:0] e_head;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            if (!prev_stall) begin
                tx_req  = ($urandom_range(0, 99) < 55);
                tx_dest = NODE_W'($urandom);
                tx_data = $urandom;
            end
            ni_ready = ($urandom_range(0, 99) < 45);
            rx_valid = ($urandom_range(0, 99) < 50);
            rx_data  = $urandom;
            wb_we    = ($urandom_range(0, 99) < ((c / 150) % 2 == 0 ? 40 : 95));
            #1;
            e_valid = (txq.size() != 0);
            e_stall = tx_req && (txq.size() == TX_DEPTH);
            e_head  = e_valid ? txq[0] : '0;
            e_we    = m_held && (!wb_we || m_denied == STARVE_MAX);
            e_hold  = m_held && (m_denied == STARVE_MAX) && wb_we;
            checks++;
            if (ni_valid !== e_valid || tx_stall !== e_stall || (e_valid && {ni_dest, ni_data} !== e_head)) begin
                failures++; $display("FAIL rand_tx c=%0d got=%0b/%0b/%h want=%0b/%0b/%h", c, ni_valid, tx_stall, {ni_dest, ni_data}, e_valid, e_stall, e_head);
            end
            checks++;
            if (rx_ready !== !m_held || rx_we !== e_we || wb_hold !== e_hold || rx_wdata !== m_word) begin
                failures++; $display("FAIL rand_rx c=%0d got=%0b/%0b/%0b/%h want=%0b/%0b/%0b/%h", c, rx_ready, rx_we, wb_hold, rx_wdata, !m_held, e_we, e_hold, m_word);
            end
            checks++;
            if (tx_sent_cnt !== m_cnt) begin failures++; $display("FAIL rand_cnt c=%0d got=%0d want=%0d", c, tx_sent_cnt, m_cnt); end
            prev_stall = e_stall;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_sat();
        idle_inputs();
        // drain anything left by the random run
        ni_ready = 1;
        for (int i = 0; i < TX_DEPTH; i++) tick();
        ni_ready = 0;
        force dut.sent_cnt_q = 16'hFFFE;
        #1;
        release dut.sent_cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            tx_req = 1; tx_dest = 2'd0; tx_data = 32'hD0 + i;
            tick();
        end
        tx_req = 0; ni_ready = 1;
        tick();
        #1;
        checks++; if (tx_sent_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_first got=%h want=ffff", tx_sent_cnt); end
        tick(); tick();
        #1;
        checks++; if (tx_sent_cnt !== 16'hFFFF || ni_valid !== 1'b0) begin failures++; $display("FAIL sat_hold got=%h/%0b want=ffff/0", tx_sent_cnt, ni_valid); end
        ni_ready = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tx_fill();
        test_full_push_pop();
        test_rx_basic();
        test_rx_starve();
        test_reset_mid();
        test_random();
        test_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
